// File: rtl/fp8_dot_pe.sv
// fp8_dot_pe: LANES-wide E4M3 dot-product PE; product, accumulate and BF16 convert stages.
// Define FP8_DOT_NAN_EN to treat S.1111.111 as NaN (result forced to 0x7FC0).
module fp8_dot_pe #(
   parameter int LANES = 4,
   parameter int ACC_W = 48
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 in_valid,
   input  logic                 in_last,
   input  logic [8*LANES-1:0]   a_in,
   input  logic [8*LANES-1:0]   b_in,
   output logic [8*LANES-1:0]   a_out,
   output logic [8*LANES-1:0]   b_out,
   output logic                 fwd_valid,
   output logic                 out_valid,
   output logic [15:0]          out_bf16
);
   localparam int SUM_W = ACC_W + 2;
   localparam int MSB_W = $clog2(ACC_W);
   localparam logic signed [SUM_W-1:0] SAT_POS = {3'b000, {(ACC_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] SAT_NEG = -SAT_POS;

   logic [8*LANES-1:0]      a_out_q, a_out_d, b_out_q, b_out_d;
   logic                    fwd_valid_q, fwd_valid_d;
   logic                    s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
   logic [LANES-1:0][36:0]  prod_q, prod_d;
   logic [ACC_W-1:0]        acc_q, acc_d;
   logic                    acc_open_q, acc_open_d;
   logic                    s2_last_q, s2_last_d;
   logic                    out_valid_q, out_valid_d;
   logic [15:0]             out_bf16_q, out_bf16_d;
   logic signed [SUM_W-1:0] lane_sum, acc_base, acc_sum;
   logic [ACC_W-1:0]        mag, norm;
   logic [MSB_W-1:0]        msb_pos;
   logic [8:0]              mant, mant_r;
   logic                    round_up;
   logic [15:0]             conv, result;
`ifdef FP8_DOT_NAN_EN
   logic                    s1_nan_q, s1_nan_d, nan_acc_q, nan_acc_d;
`endif

   // Exact signed product of two E4M3 values, LSB weight 2^-18.
   function automatic logic [36:0] lane_prod(input logic [7:0] a, input logic [7:0] b);
      logic [3:0]  sig_a, sig_b, ea, eb;
      logic [4:0]  sh;
      logic [35:0] pmag;
      sig_a = {|a[6:3], a[2:0]};
      sig_b = {|b[6:3], b[2:0]};
      ea    = (a[6:3] == 4'd0) ? 4'd1 : a[6:3];
      eb    = (b[6:3] == 4'd0) ? 4'd1 : b[6:3];
      sh    = {1'b0, ea} + {1'b0, eb} - 5'd2;
      pmag  = {28'd0, {4'd0, sig_a} * {4'd0, sig_b}} << sh;
      return (a[7] ^ b[7]) ? -{1'b0, pmag} : {1'b0, pmag};
   endfunction

   always_comb begin
      a_out_d     = a_in;
      b_out_d     = b_in;
      fwd_valid_d = in_valid;
      s1_valid_d  = in_valid & ~clear;
      s1_last_d   = in_valid & in_last & ~clear;
      for (int i = 0; i < LANES; i++) begin
         prod_d[i] = lane_prod(a_in[8*i +: 8], b_in[8*i +: 8]);
      end
   end

   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_sum = lane_sum + $signed({{(SUM_W-37){prod_q[i][36]}}, prod_q[i]});
      end
      acc_base = '0;
      if (acc_open_q) begin
         acc_base = $signed({{2{acc_q[ACC_W-1]}}, acc_q});
      end
      acc_sum    = acc_base + lane_sum;
      acc_d      = acc_q;
      acc_open_d = acc_open_q;
      s2_last_d  = 1'b0;
      if (clear) begin
         acc_d      = '0;
         acc_open_d = 1'b0;
      end else if (s1_valid_q) begin
         if (acc_sum > SAT_POS) begin
            acc_d = SAT_POS[ACC_W-1:0];
         end else if (acc_sum < SAT_NEG) begin
            acc_d = SAT_NEG[ACC_W-1:0];
         end else begin
            acc_d = acc_sum[ACC_W-1:0];
         end
         acc_open_d = ~s1_last_q;
         s2_last_d  = s1_last_q;
      end
   end

`ifdef FP8_DOT_NAN_EN
   always_comb begin
      s1_nan_d = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (a_in[8*i +: 7] == 7'h7F || b_in[8*i +: 7] == 7'h7F) begin
            s1_nan_d = 1'b1;
         end
      end
      nan_acc_d = nan_acc_q;
      if (clear) begin
         nan_acc_d = 1'b0;
      end else if (s1_valid_q) begin
         nan_acc_d = (acc_open_q & nan_acc_q) | s1_nan_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_nan_q  <= 1'b0;
         nan_acc_q <= 1'b0;
      end else begin
         s1_nan_q  <= s1_nan_d;
         nan_acc_q <= nan_acc_d;
      end
   end
`endif

   // Saturation keeps |acc| below 2^(ACC_W-1), so the negation cannot overflow.
   always_comb begin
      mag     = acc_q[ACC_W-1] ? -acc_q : acc_q;
      msb_pos = '0;
      for (int i = 0; i < ACC_W; i++) begin
         if (mag[i]) begin
            msb_pos = i[MSB_W-1:0];
         end
      end
      norm     = mag << (MSB_W'(ACC_W - 1) - msb_pos);
      mant     = {1'b0, norm[ACC_W-1 -: 8]};
      round_up = norm[ACC_W-9] & ((|norm[ACC_W-10:0]) | mant[0]);
      mant_r   = mant + {8'd0, round_up};
      conv     = {acc_q[ACC_W-1], 8'(msb_pos) + 8'd109 + {7'd0, mant_r[8]},
                  mant_r[8] ? mant_r[7:1] : mant_r[6:0]};
      if (mag == '0) begin
         conv = '0;
      end
      result = conv;
`ifdef FP8_DOT_NAN_EN
      if (nan_acc_q) begin
         result = 16'h7FC0;
      end
`endif
      out_valid_d = s2_last_q & ~clear;
      out_bf16_d  = s2_last_q ? result : out_bf16_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_out_q     <= '0;
         b_out_q     <= '0;
         fwd_valid_q <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_last_q   <= 1'b0;
         prod_q      <= '0;
         acc_q       <= '0;
         acc_open_q  <= 1'b0;
         s2_last_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_bf16_q  <= '0;
      end else begin
         a_out_q     <= a_out_d;
         b_out_q     <= b_out_d;
         fwd_valid_q <= fwd_valid_d;
         s1_valid_q  <= s1_valid_d;
         s1_last_q   <= s1_last_d;
         prod_q      <= prod_d;
         acc_q       <= acc_d;
         acc_open_q  <= acc_open_d;
         s2_last_q   <= s2_last_d;
         out_valid_q <= out_valid_d;
         out_bf16_q  <= out_bf16_d;
      end
   end

   assign a_out     = a_out_q;
   assign b_out     = b_out_q;
   assign fwd_valid = fwd_valid_q;
   assign out_valid = out_valid_q;
   assign out_bf16  = out_bf16_q;
endmodule

// File: tb/tb_fp8_dot_pe.sv
// tb_fp8_dot_pe: directed and random vectors for fp8_dot_pe, checked against a value-level model.
module tb_fp8_dot_pe;
   localparam int LANES = 4;
   localparam int ACC_W = 48;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                clear = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_last = 1'b0;
   logic [8*LANES-1:0]  a_in = '0;
   logic [8*LANES-1:0]  b_in = '0;
   logic [8*LANES-1:0]  a_out, b_out;
   logic                fwd_valid, out_valid;
   logic [15:0]         out_bf16;

   fp8_dot_pe #(.LANES(LANES), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_last(in_last),
      .a_in(a_in), .b_in(b_in), .a_out(a_out), .b_out(b_out), .fwd_valid(fwd_valid),
      .out_valid(out_valid), .out_bf16(out_bf16));

   always #5 clk = ~clk;

   typedef struct {int due; logic [15:0] val;} exp_t;

   int     n_cmp = 0;
   int     n_bad = 0;
   int     cyc = 0;
   exp_t   expq[$];
   exp_t   head;
   longint acc_m = 0;
   bit     open_m = 1'b0;
   bit     nan_m = 1'b0;
   logic [8*LANES-1:0] pa, pb;
   logic               pv;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pa <= '0; pb <= '0; pv <= 1'b0;
      end else begin
         pa <= a_in; pb <= b_in; pv <= in_valid;
      end
   end

   // Result timing/value check plus systolic forwarding check, once per cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         n_cmp++;
         assert ({a_out, b_out, fwd_valid} === {pa, pb, pv}) else begin
            n_bad++;
            $error("FAIL fwd cyc=%0d got %h/%h/%b exp %h/%h/%b", cyc, a_out, b_out, fwd_valid, pa, pb, pv);
         end
         if (expq.size() > 0 && expq[0].due == cyc) begin
            head = expq.pop_front();
            n_cmp++;
            assert ({out_valid, out_bf16} === {1'b1, head.val}) else begin
               n_bad++;
               $error("FAIL result cyc=%0d got v=%b %h exp v=1 %h", cyc, out_valid, out_bf16, head.val);
            end
         end else if (out_valid) begin
            n_cmp++;
            assert (out_valid === 1'b0) else begin
               n_bad++;
               $error("FAIL spurious cyc=%0d got v=%b %h exp v=0", cyc, out_valid, out_bf16);
            end
         end
      end
   end

   // Operand magnitude in units of 2^-9 (the smallest subnormal).
   function automatic longint val9(input logic [7:0] x);
      int     e;
      longint m;
      e = int'(x[6:3]);
      m = longint'(x[2:0]);
      if (e == 0) return m;
      return (m + 8) << (e - 1);
   endfunction

   // Round an integer count of 2^-18 units to BF16, nearest-even.
   function automatic logic [15:0] to_bf16(input longint v);
      longint m, mant, rem, half;
      int     e;
      logic   s;
      if (v == 0) return 16'h0000;
      s = (v < 0);
      m = s ? -v : v;
      e = 0;
      while ((m >> (e + 1)) != 0) e++;
      if (e <= 7) begin
         mant = m << (7 - e);
      end else begin
         mant = m >> (e - 7);
         rem  = m - (mant << (e - 7));
         half = longint'(1) << (e - 8);
         if (rem > half || (rem == half && mant[0])) mant++;
         if (mant == 256) begin
            mant = 128;
            e++;
         end
      end
      return {s, 8'(e + 109), mant[6:0]};
   endfunction

   function automatic logic [8*LANES-1:0] rnd_ops();
      logic [8*LANES-1:0] r;
      for (int i = 0; i < LANES; i++) begin
         r[8*i +: 8] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      end
      return r;
   endfunction

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
         a_in = rnd_ops(); b_in = rnd_ops();
      end
   endtask

   task automatic beat(input logic [8*LANES-1:0] a, input logic [8*LANES-1:0] b, input bit last,
                       input bit do_clear, input bit use_spec, input logic [15:0] spec_val);
      longint     s, p;
      bit         nan;
      logic [7:0] la, lb;
      logic [15:0] r;
      exp_t       keep[$];
      @(posedge clk); #1;
      in_valid = 1'b1; in_last = last; a_in = a; b_in = b; clear = do_clear;
      if (do_clear) begin
         keep = {};
         foreach (expq[k]) if (expq[k].due <= cyc) keep.push_back(expq[k]);
         expq = keep;
         acc_m = 0; open_m = 1'b0; nan_m = 1'b0;
      end else begin
         s = 0; nan = 1'b0;
         for (int i = 0; i < LANES; i++) begin
            la = a[8*i +: 8];
            lb = b[8*i +: 8];
            p = val9(la) * val9(lb);
            s += (la[7] ^ lb[7]) ? -p : p;
`ifdef FP8_DOT_NAN_EN
            if (la[6:0] == 7'h7F || lb[6:0] == 7'h7F) nan = 1'b1;
`endif
         end
         acc_m = (open_m ? acc_m : 0) + s;
         if (acc_m > (longint'(1) << (ACC_W - 1)) - 1) acc_m = (longint'(1) << (ACC_W - 1)) - 1;
         if (acc_m < -((longint'(1) << (ACC_W - 1)) - 1)) acc_m = -((longint'(1) << (ACC_W - 1)) - 1);
         nan_m  = (open_m & nan_m) | nan;
         open_m = !last;
         if (last) begin
            r = nan_m ? 16'h7FC0 : to_bf16(acc_m);
            if (use_spec) r = spec_val;
            expq.push_back('{due: cyc + 3, val: r});
         end
      end
   endtask

   initial begin
      int len;
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      assert ({a_out, b_out, fwd_valid, out_valid, out_bf16} === '0) else begin
         n_bad++;
         $error("FAIL reset_state got %h/%h/%b/%b/%h exp all 0", a_out, b_out, fwd_valid, out_valid, out_bf16);
      end
      rst_n = 1'b1;
      idle(2);

      beat(32'h38383838, 32'h40404040, 1, 0, 1, 16'h4100);
      idle(4);
      beat(32'h38383838, 32'h40404040, 0, 0, 1, 16'h0000);
      beat(32'h38383838, 32'h40404040, 0, 0, 1, 16'h0000);
      beat(32'h38383838, 32'h40404040, 1, 0, 1, 16'h41C0);
      beat(32'h00000038, 32'h00000038, 1, 0, 1, 16'h3F80);
      beat(32'h00003838, 32'h00000238, 1, 0, 1, 16'h3F80);
      beat(32'h00383838, 32'h00010238, 1, 0, 1, 16'h3F81);
      beat(32'h00000001, 32'h00000001, 1, 0, 1, 16'h3680);
      beat(32'h0000B838, 32'h00003838, 1, 0, 1, 16'h0000);
`ifdef FP8_DOT_NAN_EN
      beat(32'h7F7F7F7F, 32'h7F7F7F7F, 1, 0, 1, 16'h7FC0);
`else
      beat(32'h7F7F7F7F, 32'h7F7F7F7F, 1, 0, 1, 16'h4961);
`endif
      idle(4);

      beat(32'h38383838, 32'h40404040, 0, 0, 0, 16'h0000);
      beat(32'h38383838, 32'h40404040, 1, 1, 0, 16'h0000);
      idle(5);
      beat(32'h38383838, 32'h40404040, 1, 0, 1, 16'h4100);
      idle(4);

      // Asynchronous reset in the middle of a vector.
      beat(32'h38383838, 32'h40404040, 0, 0, 0, 16'h0000);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      assert ({a_out, b_out, fwd_valid, out_valid, out_bf16} === '0) else begin
         n_bad++;
         $error("FAIL mid_reset got %h/%h/%b/%b/%h exp all 0", a_out, b_out, fwd_valid, out_valid, out_bf16);
      end
      expq.delete();
      acc_m = 0; open_m = 1'b0; nan_m = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      rst_n = 1'b1;
      beat(32'h38383838, 32'h40404040, 1, 0, 1, 16'h4100);
      idle(3);

      for (int v = 0; v < 40; v++) begin
         len = $urandom_range(1, 4);
         for (int k = 0; k < len; k++) begin
            beat(rnd_ops(), rnd_ops(), k == len - 1, 0, 0, 16'h0000);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
      end
      idle(1);

      for (int k = 0; k < 20 && expq.size() > 0; k++) @(posedge clk);
      idle(2);
      n_cmp++;
      assert (expq.size() === 0) else begin
         n_bad++;
         $error("FAIL drain got %0d pending results exp 0", expq.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
